// File: rtl/mem_test_ctrl.sv
// mem_test_ctrl: sequences four write/read-compare passes over the memory and reports pass/fail
module mem_test_ctrl #(
  parameter int RD_WAIT     = 1,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done,
  input  logic       error,
  output logic [2:0] pass,
  output logic [2:0] state,
  output logic       loadA,
  output logic       loadD,
  output logic       we,
  output logic       oe,
  output logic       busy,
  output logic       test_done,
  output logic       test_fail
);
  typedef enum logic [3:0] {IDLE, WADR, WDAT, WRITE, RADR, RDAT, RWAIT, CMP, EVAL, PASS, FAIL} st_t;
  st_t cs, ns;
  logic [3:0] cnt;
  // state, pass number and read-wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs   <= IDLE;
      pass <= 3'd0;
      cnt  <= 4'd0;
    end else begin
      cs <= ns;
      if (cs == CMP && done && ns != FAIL) pass <= pass + 3'd1;
      if (ns == RWAIT && cs != RWAIT) cnt <= 4'(RD_WAIT - 1);
      else if (cs == RWAIT) cnt <= cnt - 4'd1;
    end
  end
  // next-state: write loop, read loop, evaluation; an early error aborts when enabled
  always_comb begin
    ns = cs;
    case (cs)
      IDLE:    ns = start ? WADR : IDLE;
      WADR:    ns = WDAT;
      WDAT:    ns = WRITE;
      WRITE:   ns = done ? RADR : WADR;
      RADR:    ns = RDAT;
      RDAT:    ns = RWAIT;
      RWAIT:   ns = (cnt == 4'd0) ? CMP : RWAIT;
      CMP:     ns = !done ? RADR : (pass == 3'd3) ? EVAL : WADR;
      EVAL:    ns = error ? FAIL : PASS;
      default: ns = cs;
    endcase
    if (STOP_ON_ERR && busy && error) ns = FAIL;
  end
  // Moore outputs decoded from the current state
  always_comb begin
    state     = (cs == IDLE) ? 3'b000 :
                (cs inside {WADR, WDAT, WRITE}) ? 3'b001 :
                (cs inside {RADR, RDAT, RWAIT}) ? 3'b010 :
                (cs == CMP) ? 3'b100 : 3'b011;
    loadA     = (cs == WADR) || (cs == RADR);
    loadD     = (cs == WDAT) || (cs == RDAT);
    we        = (cs == WRITE);
    oe        = (cs == RWAIT) || (cs == CMP);
    busy      = !(cs inside {IDLE, PASS, FAIL});
    test_done = (cs == PASS);
    test_fail = (cs == FAIL);
  end
endmodule

// File: tb/tb_mem_test_ctrl.sv
// tb_mem_test_ctrl: scoreboard bench for mem_test_ctrl over a 16-word datapath window
module tb_mem_test_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_i[2], start_i[2], inj[2];
  logic [2:0] pass_o[2], state_o[2];
  logic       la_o[2], ld_o[2], we_o[2], oe_o[2], busy_o[2], td_o[2], tf_o[2];
  // instance 0: RD_WAIT=1, STOP_ON_ERR=1; instance 1: RD_WAIT=4, STOP_ON_ERR=0
  for (genvar g = 0; g < 2; g++) begin : gi
    logic [3:0] a;
    logic       e;
    always_ff @(posedge clk or negedge rst_i[g]) begin
      if (!rst_i[g]) begin
        a <= 4'hF;
        e <= 1'b0;
      end else begin
        if (la_o[g]) a <= a + 4'd1;
        if (inj[g] && state_o[g] == 3'b100 && pass_o[g] == 3'd2 && a == 4'd5) e <= 1'b1;
      end
    end
    mem_test_ctrl #(.RD_WAIT(g == 0 ? 1 : 4), .STOP_ON_ERR(g == 0)) u (
      .clk(clk), .rst(rst_i[g]), .start(start_i[g]), .done(a == 4'hF), .error(e),
      .pass(pass_o[g]), .state(state_o[g]), .loadA(la_o[g]), .loadD(ld_o[g]),
      .we(we_o[g]), .oe(oe_o[g]), .busy(busy_o[g]), .test_done(td_o[g]), .test_fail(tf_o[g])
    );
  end
  typedef struct {int cyc; logic [12:0] v; string tag;} ent_t;
  typedef struct {int cyc; int v;} pe_t;
  ent_t cq[$];
  pe_t  pq[$];
  int tests = 0, fails = 0, cyc = 0, sel = 0;
  logic [2:0] last_pass;
  task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, x);
    end
  endtask
  function automatic logic [12:0] mk(int p, int s, bit la, bit ld, bit w, bit o, bit b, bit td, bit tf);
    return {p[2:0], s[2:0], la, ld, w, o, b, td, tf};
  endfunction
  function automatic logic [12:0] obs(int s);
    return {pass_o[s], state_o[s], la_o[s], ld_o[s], we_o[s], oe_o[s], busy_o[s], td_o[s], tf_o[s]};
  endfunction
  task automatic ex(int c, logic [12:0] v, string t);
    ent_t e;
    e.cyc = c;
    e.v = v;
    e.tag = t;
    cq.push_back(e);
  endtask
  task automatic ep(int c, int v);
    pe_t p;
    p.cyc = c;
    p.v = v;
    pq.push_back(p);
  endtask
  task automatic step();
    pe_t  p;
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (pass_o[sel] !== last_pass) begin
      if (pq.size() > 0) begin
        p = pq.pop_front();
        chk("pass_val", 32'(pass_o[sel]), p.v);
        chk("pass_cyc", cyc, p.cyc);
      end else chk("pass_unexpected", 32'(pass_o[sel]), 32'(last_pass));
      last_pass = pass_o[sel];
    end
    while (cq.size() > 0 && cq[0].cyc == cyc) begin
      e = cq.pop_front();
      chk(e.tag, 32'(obs(sel)), 32'(e.v));
    end
  endtask
  task automatic go(int s, bit held);
    sel = s;
    cyc = -1;
    last_pass = 3'd0;
    start_i[s] = 1'b1;
    step();
    if (!held) start_i[s] = 1'b0;
    while (cq.size() > 0 && cyc < 3000) step();
    chk("cq_drained", cq.size(), 0);
    chk("pq_drained", pq.size(), 0);
  endtask
  task automatic do_reset();
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i[0] = 1'b1;
    rst_i[1] = 1'b1;
  endtask
  initial begin
    inj[0] = 1'b0;
    inj[1] = 1'b0;
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset0", 32'(obs(0)), 0);
    chk("reset1", 32'(obs(1)), 0);
    rst_i[0] = 1'b1;
    rst_i[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_hold", 32'(obs(0)), 0);
    // clean run, RD_WAIT=1, pass period 16*7=112
    ex(0, mk(0, 1, 1, 0, 0, 0, 1, 0, 0), "wadr0");
    ex(1, mk(0, 1, 0, 1, 0, 0, 1, 0, 0), "wdat0");
    ex(2, mk(0, 1, 0, 0, 1, 0, 1, 0, 0), "write0");
    ex(48, mk(0, 2, 1, 0, 0, 0, 1, 0, 0), "radr0");
    ex(49, mk(0, 2, 0, 1, 0, 0, 1, 0, 0), "rdat0");
    ex(50, mk(0, 2, 0, 0, 0, 1, 1, 0, 0), "rwait0");
    ex(51, mk(0, 4, 0, 0, 0, 1, 1, 0, 0), "cmp0");
    ex(52, mk(0, 2, 1, 0, 0, 0, 1, 0, 0), "radr1");
    ex(448, mk(4, 3, 0, 0, 0, 0, 1, 0, 0), "eval");
    ex(449, mk(4, 3, 0, 0, 0, 0, 0, 1, 0), "pass_done");
    ex(455, mk(4, 3, 0, 0, 0, 0, 0, 1, 0), "pass_held");
    for (int p = 1; p <= 4; p++) ep(112 * p, p);
    go(0, 1'b0);
    // injected error, STOP_ON_ERR=1: CMP of addr 5 in pass 2 is cycle 295
    do_reset();
    inj[0] = 1'b1;
    ep(112, 1);
    ep(224, 2);
    ex(295, mk(2, 4, 0, 0, 0, 1, 1, 0, 0), "stop_cmp");
    ex(296, mk(2, 2, 1, 0, 0, 0, 1, 0, 0), "stop_radr");
    ex(297, mk(2, 3, 0, 0, 0, 0, 0, 0, 1), "stop_fail");
    ex(310, mk(2, 3, 0, 0, 0, 0, 0, 0, 1), "stop_held");
    go(0, 1'b0);
    inj[0] = 1'b0;
    // injected error, STOP_ON_ERR=0, RD_WAIT=4, start held: pass period 160
    do_reset();
    inj[1] = 1'b1;
    ex(48, mk(0, 2, 1, 0, 0, 0, 1, 0, 0), "w4_radr");
    ex(49, mk(0, 2, 0, 1, 0, 0, 1, 0, 0), "w4_rdat");
    ex(50, mk(0, 2, 0, 0, 0, 1, 1, 0, 0), "w4_rwait_a");
    ex(53, mk(0, 2, 0, 0, 0, 1, 1, 0, 0), "w4_rwait_d");
    ex(54, mk(0, 4, 0, 0, 0, 1, 1, 0, 0), "w4_cmp");
    ex(55, mk(0, 2, 1, 0, 0, 0, 1, 0, 0), "w4_radr1");
    ex(410, mk(2, 2, 1, 0, 0, 0, 1, 0, 0), "noabort");
    ex(640, mk(4, 3, 0, 0, 0, 0, 1, 0, 0), "w4_eval");
    ex(641, mk(4, 3, 0, 0, 0, 0, 0, 0, 1), "late_fail");
    ex(645, mk(4, 3, 0, 0, 0, 0, 0, 0, 1), "late_held");
    for (int p = 1; p <= 4; p++) ep(160 * p, p);
    go(1, 1'b1);
    inj[1] = 1'b0;
    // asynchronous reset in pass 1 RWAIT, then restart from pass 0
    do_reset();
    ep(112, 1);
    ex(162, mk(1, 2, 0, 0, 0, 1, 1, 0, 0), "p1_rwait");
    go(0, 1'b0);
    #2;
    rst_i[0] = 1'b0;
    #1;
    chk("async_rst", 32'(obs(0)), 0);
    @(posedge clk);
    #1;
    rst_i[0] = 1'b1;
    ex(0, mk(0, 1, 1, 0, 0, 0, 1, 0, 0), "restart_wadr");
    ex(3, mk(0, 1, 1, 0, 0, 0, 1, 0, 0), "restart_wadr1");
    go(0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
